// File: rtl/decoder_lstm_seq_mc.sv
// Sequence controller for the TSMAE decoder: steps an external LSTM cell over the input
// sequence and projects each hidden state through a saturating fixed-point MAC.
module decoder_lstm_seq_mc #(
   parameter int DATA_WIDTH     = 32,
   parameter int FRACT_WIDTH    = 24,
   parameter int HIDDEN_SIZE    = 10,
   parameter int OUT_SIZE       = 1,
   parameter int SEQ_LEN        = 10,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        start,
   input  logic                                        abort,
   input  logic                                        init_en,
   input  logic [HIDDEN_SIZE*DATA_WIDTH-1:0]           h0,
   input  logic [HIDDEN_SIZE*DATA_WIDTH-1:0]           c0,
   input  logic [SEQ_LEN*HIDDEN_SIZE*DATA_WIDTH-1:0]   z_seq,
   input  logic [OUT_SIZE*HIDDEN_SIZE*DATA_WIDTH-1:0]  w_out,
   input  logic [OUT_SIZE*DATA_WIDTH-1:0]              b_out,
   output logic                                        cell_start,
   output logic [HIDDEN_SIZE*DATA_WIDTH-1:0]           cell_x,
   output logic [HIDDEN_SIZE*DATA_WIDTH-1:0]           cell_h_prev,
   output logic [HIDDEN_SIZE*DATA_WIDTH-1:0]           cell_c_prev,
   input  logic [HIDDEN_SIZE*DATA_WIDTH-1:0]           cell_h_next,
   input  logic [HIDDEN_SIZE*DATA_WIDTH-1:0]           cell_c_next,
   input  logic                                        cell_done,
   output logic [SEQ_LEN*OUT_SIZE*DATA_WIDTH-1:0]      x_recon,
   output logic [HIDDEN_SIZE*DATA_WIDTH-1:0]           h_out,
   output logic [HIDDEN_SIZE*DATA_WIDTH-1:0]           c_out,
   output logic                                        step_valid,
   output logic                                        busy,
   output logic                                        done,
   output logic                                        timeout_err
);

   // state  | meaning
   // IDLE   | waiting for start
   // INIT   | t=0, load h/c from h0/c0 or zero
   // CSTART | cell_start pulse
   // CWAIT  | waiting for cell_done, timeout down-counter running
   // MAC    | one product h[k]*w[o][k] per cycle
   // STORE  | saturate acc+bias into x_recon[t][o]
   // UPDATE | step_valid pulse, advance t
   // FIN    | done pulse, final states published
   typedef enum logic [2:0] {IDLE, INIT, CSTART, CWAIT, MAC, STORE, UPDATE, FIN} state_t;

   localparam int HW    = HIDDEN_SIZE*DATA_WIDTH;
   localparam int TW    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
   localparam int OW    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
   localparam int KW    = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1;
   localparam int CW    = $clog2(TIMEOUT_CYCLES+1);
   // Wide enough that a shifted full-scale product summed HIDDEN_SIZE times plus bias never wraps.
   localparam int ACC_W = 2*DATA_WIDTH - FRACT_WIDTH + KW + 1;
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   state_t                    state;
   logic [HW-1:0]             h_reg, c_reg;
   logic [TW-1:0]             t;
   logic [OW-1:0]             o;
   logic [KW-1:0]             k;
   logic [CW-1:0]             cnt;
   logic signed [ACC_W-1:0]   acc;
   logic                      init_q;

   logic signed [DATA_WIDTH-1:0]   mac_w, mac_h, bias;
   logic signed [2*DATA_WIDTH-1:0] mac_prod, mac_shift;
   logic signed [ACC_W-1:0]        acc_next, acc_bias;
   logic [DATA_WIDTH-1:0]          sat_val;

   assign cell_x      = z_seq[int'(t)*HW +: HW];
   assign cell_h_prev = h_reg;
   assign cell_c_prev = c_reg;

   always_comb begin
      mac_w     = w_out[(int'(o)*HIDDEN_SIZE + int'(k))*DATA_WIDTH +: DATA_WIDTH];
      mac_h     = h_reg[int'(k)*DATA_WIDTH +: DATA_WIDTH];
      mac_prod  = mac_w * mac_h;
      mac_shift = mac_prod >>> FRACT_WIDTH;
      acc_next  = acc + ACC_W'(mac_shift);
      bias      = b_out[int'(o)*DATA_WIDTH +: DATA_WIDTH];
      acc_bias  = acc + ACC_W'(bias);
      if (acc_bias > SAT_MAX)
         sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (acc_bias < SAT_MIN)
         sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else
         sat_val = acc_bias[DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         h_reg       <= '0;
         c_reg       <= '0;
         t           <= '0;
         o           <= '0;
         k           <= '0;
         cnt         <= '0;
         acc         <= '0;
         init_q      <= 1'b0;
         x_recon     <= '0;
         h_out       <= '0;
         c_out       <= '0;
         cell_start  <= 1'b0;
         step_valid  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         cell_start <= 1'b0;
         step_valid <= 1'b0;
         done       <= 1'b0;
         if (abort && state != IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
            acc   <= '0;
            k     <= '0;
            o     <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     init_q <= init_en;
                     busy   <= 1'b1;
                     state  <= INIT;
                  end
               end
               INIT: begin
                  t           <= '0;
                  o           <= '0;
                  k           <= '0;
                  acc         <= '0;
                  timeout_err <= 1'b0;
                  h_reg       <= init_q ? h0 : '0;
                  c_reg       <= init_q ? c0 : '0;
                  cell_start  <= 1'b1;
                  state       <= CSTART;
               end
               CSTART: begin
                  cnt   <= CW'(TIMEOUT_CYCLES-1);
                  state <= CWAIT;
               end
               CWAIT: begin
                  if (cell_done) begin
                     h_reg <= cell_h_next;
                     c_reg <= cell_c_next;
                     state <= MAC;
                  end else if (cnt == '0) begin
                     timeout_err <= 1'b1;
                     h_out       <= h_reg;
                     c_out       <= c_reg;
                     done        <= 1'b1;
                     state       <= FIN;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               MAC: begin
                  acc <= acc_next;
                  if (k == KW'(HIDDEN_SIZE-1))
                     state <= STORE;
                  else
                     k <= k + 1'b1;
               end
               STORE: begin
                  x_recon[(int'(t)*OUT_SIZE + int'(o))*DATA_WIDTH +: DATA_WIDTH] <= sat_val;
                  acc <= '0;
                  k   <= '0;
                  if (o == OW'(OUT_SIZE-1)) begin
                     step_valid <= 1'b1;
                     state      <= UPDATE;
                  end else begin
                     o     <= o + 1'b1;
                     state <= MAC;
                  end
               end
               UPDATE: begin
                  o <= '0;
                  if (t == TW'(SEQ_LEN-1)) begin
                     h_out <= h_reg;
                     c_out <= c_reg;
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     t          <= t + 1'b1;
                     cell_start <= 1'b1;
                     state      <= CSTART;
                  end
               end
               FIN: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_decoder_lstm_seq_mc.sv
// Scoreboard bench for decoder_lstm_seq_mc with a behavioural LSTM cell stand-in
// (h_next = h_prev + x, c_next = c_prev - x, answers 3 cycles after cell_start).
module tb_decoder_lstm_seq_mc;
   localparam int DW = 32;
   localparam int H  = 2;
   localparam int O  = 2;
   localparam int S  = 3;
   localparam int TO = 8;
   localparam int ONE = 1 << 24;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, abort = 1'b0, init_en = 1'b0;
   logic [H*DW-1:0]   h0 = '0, c0 = '0;
   logic [S*H*DW-1:0] z_seq = '0;
   logic [O*H*DW-1:0] w_out = '0;
   logic [O*DW-1:0]   b_out = '0;
   logic              cell_start;
   logic [H*DW-1:0]   cell_x, cell_h_prev, cell_c_prev;
   logic [H*DW-1:0]   cell_h_next = '0, cell_c_next = '0;
   logic              cell_done = 1'b0;
   logic [S*O*DW-1:0] x_recon;
   logic [H*DW-1:0]   h_out, c_out;
   logic              step_valid, busy, done, timeout_err;

   decoder_lstm_seq_mc #(
      .DATA_WIDTH(DW), .FRACT_WIDTH(24), .HIDDEN_SIZE(H), .OUT_SIZE(O),
      .SEQ_LEN(S), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .init_en(init_en),
      .h0(h0), .c0(c0), .z_seq(z_seq), .w_out(w_out), .b_out(b_out),
      .cell_start(cell_start), .cell_x(cell_x), .cell_h_prev(cell_h_prev),
      .cell_c_prev(cell_c_prev), .cell_h_next(cell_h_next), .cell_c_next(cell_c_next),
      .cell_done(cell_done), .x_recon(x_recon), .h_out(h_out), .c_out(c_out),
      .step_valid(step_valid), .busy(busy), .done(done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int fin_pushed = 0;
   bit cell_mode = 1'b1;

   typedef struct { int row; logic [31:0] v0; logic [31:0] v1; } row_t;
   typedef struct { logic [31:0] h0; logic [31:0] h1; logic [31:0] c0; logic [31:0] c1;
                    logic terr; int cyc; } fin_t;
   row_t rq[$];
   fin_t fq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] xr(input int tt, input int oo);
      return x_recon[(tt*O + oo)*DW +: DW];
   endfunction

   // Behavioural cell
   initial begin
      forever begin
         @(posedge clk); #1;
         if (cell_start && cell_mode && !rst) begin
            repeat (3) @(posedge clk);
            #1;
            for (int i = 0; i < H; i++) begin
               cell_h_next[i*DW +: DW] = cell_h_prev[i*DW +: DW] + cell_x[i*DW +: DW];
               cell_c_next[i*DW +: DW] = cell_c_prev[i*DW +: DW] - cell_x[i*DW +: DW];
            end
            cell_done = 1'b1;
            @(posedge clk); #1;
            cell_done = 1'b0;
         end
      end
   end

   // Monitor
   always @(negedge clk) begin
      row_t r;
      fin_t f;
      if (!rst) begin
         if (step_valid) begin
            if (rq.size() == 0) begin
               checks++; failures++;
               $display("FAIL step_valid: unexpected pulse at cycle %0d", cyc);
            end else begin
               r = rq.pop_front();
               chk($sformatf("row%0d_o0", r.row), {32'd0, xr(r.row, 0)}, {32'd0, r.v0});
               chk($sformatf("row%0d_o1", r.row), {32'd0, xr(r.row, 1)}, {32'd0, r.v1});
            end
         end
         if (done) begin
            done_cnt++;
            if (fq.size() == 0) begin
               checks++; failures++;
               $display("FAIL done: unexpected pulse at cycle %0d", cyc);
            end else begin
               f = fq.pop_front();
               chk("h_out0", {32'd0, h_out[31:0]},  {32'd0, f.h0});
               chk("h_out1", {32'd0, h_out[63:32]}, {32'd0, f.h1});
               chk("c_out0", {32'd0, c_out[31:0]},  {32'd0, f.c0});
               chk("c_out1", {32'd0, c_out[63:32]}, {32'd0, f.c1});
               chk("timeout_err_at_done", {63'd0, timeout_err}, {63'd0, f.terr});
               chk("done_cycle", 64'(cyc), 64'(f.cyc));
            end
         end
      end
   end

   task automatic set_cfg(input logic [31:0] zv, w00, w01, w10, w11, b0v, b1v,
                          input logic ie, input logic [31:0] hh0, hh1, cc0, cc1);
      for (int i = 0; i < S*H; i++) z_seq[i*DW +: DW] = zv;
      w_out   = {w11, w10, w01, w00};
      b_out   = {b1v, b0v};
      h0      = {hh1, hh0};
      c0      = {cc1, cc0};
      init_en = ie;
   endtask

   task automatic push_row(input int r, input logic [31:0] a, input logic [31:0] b);
      rq.push_back('{r, a, b});
   endtask

   // Raise start after an edge; done is expected lat cycles after that point.
   task automatic kick(input logic [31:0] eh0, eh1, ec0, ec1, input logic terr,
                       input int lat, input bit hold);
      int sc;
      @(posedge clk); #1;
      start = 1'b1;
      sc = cyc;
      fq.push_back('{eh0, eh1, ec0, ec1, terr, sc + lat});
      fin_pushed++;
      if (!hold) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) return;
      end
      checks++; failures++;
      $display("FAIL wait_done: no done within 200 cycles");
   endtask

   task automatic cfg_a_rows();
      push_row(0, 5*ONE/2, 0);
      push_row(1, 9*ONE/2, 0);
      push_row(2, 13*ONE/2, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int saved;
      int seen;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_terr", {63'd0, timeout_err}, 64'd0);
      chk("rst_cell_start", {63'd0, cell_start}, 64'd0);
      chk("rst_x_recon_lo", x_recon[63:0], 64'd0);
      chk("rst_h_out", h_out, 64'd0);

      // Zero-state run with start held high through the whole run.
      set_cfg(ONE, ONE, ONE, ONE, -ONE, ONE/2, 0, 1'b0, 0, 0, 0, 0);
      cfg_a_rows();
      kick(3*ONE, 3*ONE, -3*ONE, -3*ONE, 1'b0, 35, 1'b1);
      wait_done();
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("held_start_busy", {63'd0, busy}, 64'd0);
      chk("held_start_done_count", 64'(done_cnt), 64'(fin_pushed));

      // Back-to-back: start in the IDLE cycle right after FIN.
      cfg_a_rows();
      kick(3*ONE, 3*ONE, -3*ONE, -3*ONE, 1'b0, 35, 1'b0);
      wait_done();
      cfg_a_rows();
      kick(3*ONE, 3*ONE, -3*ONE, -3*ONE, 1'b0, 35, 1'b0);
      chk("b2b_busy", {63'd0, busy}, 64'd1);
      wait_done();

      // h0/c0 preload.
      set_cfg(ONE, ONE, ONE, ONE, -ONE, ONE/2, 0, 1'b1, 2*ONE, -ONE, ONE/2, ONE/4);
      push_row(0, 7*ONE/2, 3*ONE);
      push_row(1, 11*ONE/2, 3*ONE);
      push_row(2, 15*ONE/2, 3*ONE);
      kick(5*ONE, 2*ONE, ONE/2 - 3*ONE, ONE/4 - 3*ONE, 1'b0, 35, 1'b0);
      wait_done();

      // Saturation both ways.
      set_cfg(0, 127*ONE, 0, -127*ONE, 0, 0, 0, 1'b1, 127*ONE, 0, 0, 0);
      for (int r = 0; r < S; r++) push_row(r, 32'h7FFF_FFFF, 32'h8000_0000);
      kick(127*ONE, 0, 0, 0, 1'b0, 35, 1'b0);
      wait_done();

      // Product shift rounds toward minus infinity.
      set_cfg(0, 32'hFFFF_FFFF, 0, 1, 0, 0, 0, 1'b1, 1, 0, 0, 0);
      for (int r = 0; r < S; r++) push_row(r, 32'hFFFF_FFFF, 0);
      kick(1, 0, 0, 0, 1'b0, 35, 1'b0);
      wait_done();

      // Cell never answers: timeout after TO cycles in CWAIT.
      cell_mode = 1'b0;
      set_cfg(ONE, ONE, ONE, ONE, -ONE, ONE/2, 0, 1'b1, ONE, 2*ONE, 3*ONE, 4*ONE);
      kick(ONE, 2*ONE, 3*ONE, 4*ONE, 1'b1, 11, 1'b0);
      wait_done();
      repeat (3) @(negedge clk);
      chk("terr_sticky", {63'd0, timeout_err}, 64'd1);
      chk("terr_busy", {63'd0, busy}, 64'd0);
      cell_mode = 1'b1;

      // Next accepted start clears the error.
      set_cfg(ONE, ONE, ONE, ONE, -ONE, ONE/2, 0, 1'b0, 0, 0, 0, 0);
      cfg_a_rows();
      kick(3*ONE, 3*ONE, -3*ONE, -3*ONE, 1'b0, 35, 1'b0);
      @(posedge clk); #1;
      chk("terr_cleared", {63'd0, timeout_err}, 64'd0);
      wait_done();

      // Reset mid-run after row 0 was written.
      push_row(0, 5*ONE/2, 0);
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_row0", {32'd0, xr(0, 0)}, 64'd0);
      chk("midrst_h_out", h_out, 64'd0);
      @(posedge clk); #1 rst = 1'b0;

      // Abort during MAC of step 1.
      push_row(0, 5*ONE/2, 0);
      saved = done_cnt;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen = 0;
      for (int i = 0; i < 100 && seen < 2; i++) begin
         @(negedge clk);
         if (cell_done) seen++;
      end
      chk("abort_cell_done_seen", 64'(seen), 64'd2);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      repeat (40) @(negedge clk);
      chk("abort_no_done", 64'(done_cnt), 64'(saved));
      chk("abort_row0_kept", {32'd0, xr(0, 0)}, {32'd0, 32'(5*ONE/2)});
      chk("abort_row1_o0", {32'd0, xr(1, 0)}, 64'd0);
      chk("abort_row1_o1", {32'd0, xr(1, 1)}, 64'd0);
      chk("abort_h_out", h_out, 64'd0);

      chk("rowq_empty", 64'(rq.size()), 64'd0);
      chk("finq_empty", 64'(fq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
